// File: rtl/key_sched_iter.sv
// rtl/key_sched_iter.sv - iterative round-key generator with registered key bank
`timescale 1ns/1ps
module key_sched_iter #(
  parameter int NROUNDS = 10,
  parameter int IDXW    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [127:0]      key_in,
  output logic              busy,
  output logic              rk_valid,
  output logic [127:0]      rk_out,
  output logic [IDXW-1:0]   rk_idx,
  output logic              done,
  output logic              bank_ready,
  input  logic [IDXW-1:0]   rd_idx,
  output logic [127:0]      rd_key
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;
  localparam logic [IDXW-1:0] LAST = IDXW'(NROUNDS);

  localparam logic [0:255][7:0] SBOX = {
    128'hd690e9fecce13db716b614c228fb2c05,
    128'h2b679a762abe04c3aa44132649860699,
    128'h9c4250f491ef987a33540b43edcfac62,
    128'he4b31ca9c908e89580df94fa758f3fa6,
    128'h4707a7fcf37317ba83593c19e6854fa8,
    128'h686b81b27164da8bf8eb0f4b70569d35,
    128'h1e240e5e6358d1a225227c3b01217887,
    128'hd40046579fd327524c3602e7a0c4c89e,
    128'heabf8ad240c738b5a3f7f2cef96115a1,
    128'he0ae5da49b341a55ad933230f58cb1e3,
    128'h1df6e22e8266ca60c02923ab0d534e6f,
    128'hd5db3745defd8e2f03ff6a726d6c5b51,
    128'h8d1baf92bbddbc7f11d95c411f105ad8,
    128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
    128'h8969974a0c96777e65b9f109c56ec684,
    128'h18f07dec3adc4d2079ee5f3ed7cb3948
  };

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

  logic [0:0]      state;
  logic [IDXW-1:0] r;
  logic [127:0]    work;
  logic [7:0]      rc;
  logic [127:0]    bank [2**IDXW];

  logic [31:0]  t, c0, c1, c2, c3;
  logic [127:0] next_key;
  logic [7:0]   rc_next;

  // rc always holds the Rcon byte for round r+1, so it feeds the next key directly
  assign t        = sub_word({work[23:0], work[31:24]}) ^ {rc, 24'h0};
  assign c0       = work[127:96] ^ t;
  assign c1       = c0 ^ work[95:64];
  assign c2       = c1 ^ work[63:32];
  assign c3       = c2 ^ work[31:0];
  assign next_key = {c0, c1, c2, c3};
  assign rc_next  = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);

  assign busy     = (state == S_RUN);
  assign rk_valid = busy;
  assign rk_out   = busy ? work : '0;
  assign rk_idx   = busy ? r : '0;
  assign done     = busy && (r == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      r          <= '0;
      work       <= '0;
      rc         <= 8'h01;
      bank_ready <= 1'b0;
      rd_key     <= '0;
      bank       <= '{default: '0};
    end else begin
      // nonblocking read here gives read-before-write against the bank update below
      rd_key <= (rd_idx <= LAST) ? bank[rd_idx] : '0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state      <= S_RUN;
            work       <= key_in;
            r          <= '0;
            rc         <= 8'h01;
            bank_ready <= 1'b0;
          end
        end
        default: begin
          bank[r] <= work;
          if (r == LAST) begin
            state      <= S_IDLE;
            bank_ready <= 1'b1;
          end else begin
            work <= next_key;
            r    <= r + IDXW'(1);
            rc   <= rc_next;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_sched_iter.sv
// tb/tb_key_sched_iter.sv - randomized model-checked bench for key_sched_iter (10- and 14-round builds)
`timescale 1ns/1ps
module tb_key_sched_iter;

  localparam int IDXW = 4;
  localparam int NA = 10;
  localparam int NB = 14;
  localparam logic [127:0] K1  = 128'h1d0e070381c06030984c2693492492c9;
  localparam logic [127:0] R1K = 128'h8d53de5a0c93be6a94df98f9ddfb0a30;
  localparam logic [127:0] R1Z = 128'hd7d6d6d6d7d6d6d6d7d6d6d6d7d6d6d6;

  localparam logic [0:255][7:0] SB = {
    128'hd690e9fecce13db716b614c228fb2c05, 128'h2b679a762abe04c3aa44132649860699,
    128'h9c4250f491ef987a33540b43edcfac62, 128'he4b31ca9c908e89580df94fa758f3fa6,
    128'h4707a7fcf37317ba83593c19e6854fa8, 128'h686b81b27164da8bf8eb0f4b70569d35,
    128'h1e240e5e6358d1a225227c3b01217887, 128'hd40046579fd327524c3602e7a0c4c89e,
    128'heabf8ad240c738b5a3f7f2cef96115a1, 128'he0ae5da49b341a55ad933230f58cb1e3,
    128'h1df6e22e8266ca60c02923ab0d534e6f, 128'hd5db3745defd8e2f03ff6a726d6c5b51,
    128'h8d1baf92bbddbc7f11d95c411f105ad8, 128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
    128'h8969974a0c96777e65b9f109c56ec684, 128'h18f07dec3adc4d2079ee5f3ed7cb3948
  };

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start;
  logic [127:0] key_in;
  logic [IDXW-1:0] rd_idx;

  logic busy_a, rk_valid_a, done_a, bank_ready_a;
  logic [127:0] rk_out_a, rd_key_a;
  logic [IDXW-1:0] rk_idx_a;
  logic busy_b, rk_valid_b, done_b, bank_ready_b;
  logic [127:0] rk_out_b, rd_key_b;
  logic [IDXW-1:0] rk_idx_b;

  key_sched_iter #(.NROUNDS(NA), .IDXW(IDXW)) dut_a (
    .clk(clk), .rst(rst), .start(start), .key_in(key_in),
    .busy(busy_a), .rk_valid(rk_valid_a), .rk_out(rk_out_a), .rk_idx(rk_idx_a),
    .done(done_a), .bank_ready(bank_ready_a), .rd_idx(rd_idx), .rd_key(rd_key_a)
  );

  key_sched_iter #(.NROUNDS(NB), .IDXW(IDXW)) dut_b (
    .clk(clk), .rst(rst), .start(start), .key_in(key_in),
    .busy(busy_b), .rk_valid(rk_valid_b), .rk_out(rk_out_b), .rk_idx(rk_idx_b),
    .done(done_b), .bank_ready(bank_ready_b), .rd_idx(rd_idx), .rd_key(rd_key_b)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout required=event", name);
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] rcon_byte(input int n);
    int v = 1;
    for (int k = 1; k < n; k++) begin
      v = v * 2;
      if (v >= 256) v = v ^ 'h11b;
    end
    return 8'(v);
  endfunction

  function automatic logic [31:0] subrot(input logic [31:0] w);
    logic [31:0] x;
    x = {w[23:0], w[31:24]};
    return {SB[x[31:24]], SB[x[23:16]], SB[x[15:8]], SB[x[7:0]]};
  endfunction

  // Classic word-wise expansion: w[i] = w[i-4] ^ f(w[i-1])
  task automatic expand(input logic [127:0] k, input int n, output logic [127:0] ks [15]);
    logic [31:0] w [60];
    logic [31:0] tmp;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 4*(n+1); i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) tmp = subrot(tmp) ^ {rcon_byte(i/4), 24'h0};
      w[i] = w[i-4] ^ tmp;
    end
    for (int j = 0; j < 15; j++) ks[j] = (j <= n) ? {w[4*j], w[4*j+1], w[4*j+2], w[4*j+3]} : '0;
  endtask

  int nr [2] = '{NA, NB};
  logic m_run [2];
  int m_r [2];
  logic m_ready [2];
  logic [127:0] m_rdkey [2];
  logic [127:0] m_sched [2][15];
  logic [127:0] m_bank [2][16];
  logic chk_en = 1'b0;

  task automatic cmp_inst(input int i, input string p, input logic bz, input logic vl,
                          input logic [127:0] ro, input logic [IDXW-1:0] ri, input logic dn,
                          input logic br, input logic [127:0] rk);
    chk({p, "_busy"}, bz, m_run[i]);
    chk({p, "_rk_valid"}, vl, m_run[i]);
    chk({p, "_rk_out"}, ro, m_run[i] ? m_sched[i][m_r[i]] : '0);
    chk({p, "_rk_idx"}, ri, m_run[i] ? m_r[i] : 0);
    chk({p, "_done"}, dn, m_run[i] && m_r[i] == nr[i]);
    chk({p, "_bank_ready"}, br, m_ready[i]);
    chk({p, "_rd_key"}, rk, m_rdkey[i]);
  endtask

  initial begin : model_and_compare
    logic s_rst, s_start;
    logic [127:0] s_key;
    logic [IDXW-1:0] s_rd;
    logic [127:0] ks [15];
    forever begin
      @(posedge clk);
      s_rst = rst; s_start = start; s_key = key_in; s_rd = rd_idx;
      for (int i = 0; i < 2; i++) begin
        if (s_rst) begin
          m_run[i] = 1'b0; m_r[i] = 0; m_ready[i] = 1'b0; m_rdkey[i] = '0;
          for (int j = 0; j < 16; j++) m_bank[i][j] = '0;
        end else begin
          m_rdkey[i] = (int'(s_rd) <= nr[i]) ? m_bank[i][s_rd] : '0;
          if (m_run[i]) begin
            m_bank[i][m_r[i]] = m_sched[i][m_r[i]];
            if (m_r[i] == nr[i]) begin
              m_run[i] = 1'b0;
              m_ready[i] = 1'b1;
            end else begin
              m_r[i]++;
            end
          end else if (s_start) begin
            expand(s_key, nr[i], ks);
            for (int j = 0; j < 15; j++) m_sched[i][j] = ks[j];
            m_run[i] = 1'b1; m_r[i] = 0; m_ready[i] = 1'b0;
          end
        end
      end
      if (s_rst) chk_en = 1'b1;
      @(negedge clk);
      if (chk_en) begin
        cmp_inst(0, "a", busy_a, rk_valid_a, rk_out_a, rk_idx_a, done_a, bank_ready_a, rd_key_a);
        cmp_inst(1, "b", busy_b, rk_valid_b, rk_out_b, rk_idx_b, done_b, bank_ready_b, rd_key_b);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_pulse(input logic [127:0] k);
    start = 1'b1;
    key_in = k;
    cyc(1);
    start = 1'b0;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic wait_idle();
    int n = 0;
    while ((busy_a || busy_b) && n < 40) begin cyc(1); n++; end
    if (n >= 40) timeout("wait_idle");
  endtask

  initial begin : main
    logic [127:0] ks_a [15];
    logic [127:0] ks_b [15];
    logic [127:0] got_a [16];
    logic [127:0] k2;
    int n, n_a, n_b;

    rst = 1'b1; start = 1'b0; key_in = '0; rd_idx = '0;

    // pin the model with hand-computed values
    chk("sbox_00", SB[8'h00], 8'hd6);
    chk("sbox_c9", SB[8'hc9], 8'hd9);
    chk("rcon_9", rcon_byte(9), 8'h1b);
    chk("rcon_11", rcon_byte(11), 8'h6c);
    chk("rcon_12", rcon_byte(12), 8'hd8);
    chk("rcon_13", rcon_byte(13), 8'hab);
    chk("rcon_14", rcon_byte(14), 8'h4d);
    expand(K1, NA, ks_a);
    chk("model_k1_r1", ks_a[1], R1K);
    expand('0, NA, ks_b);
    chk("model_zero_r1", ks_b[1], R1Z);

    cyc(2);
    chk("reset_busy", busy_a, 1'b0);
    chk("reset_rk_out", rk_out_a, '0);
    chk("reset_bank_ready", bank_ready_a, 1'b0);
    chk("reset_rd_key", rd_key_b, '0);
    rst = 1'b0;
    cyc(1);

    // first schedule, with an ignored start mid-run
    start_pulse(K1);
    n = 1; n_a = 0; n_b = 0;
    for (int j = 0; j < 16; j++) got_a[j] = '0;
    while ((n_a == 0 || n_b == 0) && n < 40) begin
      if (rk_valid_a) got_a[rk_idx_a] = rk_out_a;
      if (done_a && n_a == 0) n_a = n;
      if (done_b && n_b == 0) n_b = n;
      if (n_a != 0 && n == n_a + 1) chk("bank_ready_after_done", bank_ready_a, 1'b1);
      start = (n == 4);
      key_in = ~K1;
      cyc(1);
      n++;
    end
    start = 1'b0;
    if (n >= 40) timeout("run1_done");
    chk("round0_echo", got_a[0], K1);
    chk("round1_k1", got_a[1], R1K);
    chk("done_latency_a", n_a, 11);
    chk("done_latency_b", n_b, 15);
    cyc(1);

    // bank readback for both builds
    expand(K1, NA, ks_a);
    expand(K1, NB, ks_b);
    for (int idx = 0; idx < 16; idx++) begin
      rd_idx = IDXW'(idx);
      cyc(1);
      chk($sformatf("rd_a_%0d", idx), rd_key_a, (idx <= NA) ? ks_a[idx] : '0);
      chk($sformatf("rd_b_%0d", idx), rd_key_b, (idx <= NB) ? ks_b[idx] : '0);
    end

    // zero key, then back-to-back start on the cycle after done
    start_pulse('0);
    n = 1;
    while (!done_a && n < 40) begin
      if (rk_valid_a && rk_idx_a == 1) chk("round1_zero", rk_out_a, R1Z);
      cyc(1);
      n++;
    end
    if (n >= 40) timeout("run2_done");
    cyc(1);
    k2 = rnd128();
    start_pulse(k2);
    chk("b2b_valid", rk_valid_a, 1'b1);
    chk("b2b_idx", rk_idx_a, 0);
    chk("b2b_key", rk_out_a, k2);
    chk("b2b_ready_low", bank_ready_a, 1'b0);
    wait_idle();
    cyc(1);

    // reset mid-run at round 5, with a simultaneous start that must be ignored
    start_pulse(rnd128());
    n = 0;
    while (rk_idx_a != 5 && n < 40) begin cyc(1); n++; end
    if (n >= 40) timeout("reach_round5");
    rst = 1'b1; start = 1'b1; key_in = rnd128();
    cyc(1);
    rst = 1'b0; start = 1'b0;
    chk("rst_busy", busy_a, 1'b0);
    chk("rst_valid", rk_valid_a, 1'b0);
    chk("rst_ready", bank_ready_a, 1'b0);
    chk("rst_busy_b", busy_b, 1'b0);
    for (int idx = 0; idx < 16; idx++) begin
      rd_idx = IDXW'(idx);
      cyc(1);
      chk($sformatf("rst_rd_a_%0d", idx), rd_key_a, '0);
      chk($sformatf("rst_rd_b_%0d", idx), rd_key_b, '0);
    end

    // randomized traffic; the model process checks every cycle
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(0, 149) == 0);
      start = ($urandom_range(0, 5) == 0);
      key_in = rnd128();
      rd_idx = IDXW'($urandom_range(0, 15));
      cyc(1);
    end
    rst = 1'b0; start = 1'b0;
    wait_idle();
    cyc(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/key_sched_iter.md
# key_sched_iter

Iterative, parametrised AES-style round-key generator. It accepts a 128-bit cipher key with a start pulse and produces one round key per clock through the team's custom S-box, RotWord and Rcon schedule. Every round key is streamed out as it is produced and also stored in an internal key bank. The cipher datapath reads the bank by round index, so it no longer has to chain a combinational key-generation stage per round.

## Interface
Parameters:
- NROUNDS, 10: round keys generated after the cipher key; legal range 1..14.
- IDXW, 4: width of round-index ports; must satisfy 2^IDXW > NROUNDS.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset; one clock, synchronous, active-high.
- start  in  1  one-cycle request; samples key_in.
- key_in  in  128  cipher key, word 0 = [127:96].
- busy  out  1  high while the schedule is running.
- rk_valid  out  1  rk_out/rk_idx hold a new round key this cycle.
- rk_out  out  128  streamed round key.
- rk_idx  out  IDXW  round number of rk_out (0 = cipher key).
- done  out  1  one-cycle pulse with the last round key.
- bank_ready  out  1  the bank holds a complete schedule.
- rd_idx  in  IDXW  bank read address.
- rd_key  out  128  bank read data, registered.

## Operation
- FSM states are IDLE and RUN.
- IDLE -> RUN on start: capture key_in into the working register and set round counter r=0.
- RUN, each cycle:
  - Emit the working key as round r and write it to bank[r].
  - If r==NROUNDS: assert done, go to IDLE, set bank_ready.
  - Otherwise: working key <= next(working key, r+1) and r <= r+1.
- next(K, n) with K = {w0,w1,w2,w3}:
  - t = SubWord(RotWord(w3)) ^ Rcon(n).
  - c0 = w0^t; c1 = c0^w1; c2 = c1^w2; c3 = c2^w3.
  - Result is {c0,c1,c2,c3}.
- RotWord is {w[23:0], w[31:24]}. SubWord applies the project S-box to each byte (e.g. 00->d6, 24->91, 49->59, 92->5d, c9->d9).
- Rcon(n) = {rc_n, 24'h0}. rc_1 = 01 and rc_(n+1) = xtime(rc_n) over GF(2^8) with polynomial 0x11b. Sequence: 01 02 04 08 10 20 40 80 1b 36 6c d8 ab 4d. It is generated by a register doubled each round, not by a table.
- start in RUN is ignored. The schedule in flight is not disturbed.
- start in IDLE clears bank_ready on the accept edge. bank_ready stays low until the new schedule completes, so the bank never presents mixed schedules as ready.
- Bank read: rd_key <= bank[rd_idx] every cycle. An rd_idx greater than NROUNDS returns 0. Reads are allowed while RUN; they return old or new contents per the write order below.
- A write to bank[r] and a read of the same index in the same cycle returns the old contents (read-before-write).

## Timing
- Reset values: FSM=IDLE, busy=0, rk_valid=0, rk_out=0, rk_idx=0, done=0, bank_ready=0, rd_key=0, all bank entries 0, rc register=01.
- Start accepted at edge T:
  - busy=1 from T+1.
  - Round r is valid in cycle T+1+r.
  - done and the last rk_valid fall in cycle T+1+NROUNDS.
  - busy=0 and bank_ready=1 from T+2+NROUNDS.
- Total schedule is NROUNDS+1 cycles. rk_valid is contiguous, with no bubbles.
- Back-to-back: a start in the cycle right after done is accepted, giving a zero-cycle gap.
- rst during RUN: next cycle every output takes its reset value and the bank is cleared. A start in the same cycle as rst is ignored.
- Read latency is 1 cycle.
- Critical path: S-box -> 4 XOR stages per cycle. No multi-cycle paths.

## Test plan
- Reset, then start with key 1d0e070381c06030984c2693492492c9 -> round 0 echoes the key; round 1 = 8d53de5a0c93be6a94df98f9ddfb0a30; done at round 10 exactly 11 cycles after start; bank_ready one cycle later.
- All-zero key -> round 1 = d7d6d6d6d7d6d6d6d7d6d6d6d7d6d6d6; rk_idx counts 0..10 with no gaps.
- After completion, read rd_idx 0..10 -> rd_key matches the streamed keys one cycle after each address; rd_idx=11..15 -> 0.
- start pulsed mid-RUN with a different key -> stream unchanged. Issue a new start the cycle after done -> second schedule begins with zero gap and bank_ready low for its duration.
- rst asserted at round 5 -> next cycle busy=0, rk_valid=0, bank_ready=0, and all bank reads return 0.
- NROUNDS=14 build -> Rcon bytes for rounds 11..14 are 6c, d8, ab, 4d (checked against a reference model); done at round 14.
